// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } state_t;

   localparam logic [6:0] SEG_OFF = 7'b0000000;

   // Bit positions of each segment within the {g,f,e,d,c,b,a} bus
   localparam int unsigned SEG_A = 0;
   localparam int unsigned SEG_B = 1;
   localparam int unsigned SEG_C = 2;
   localparam int unsigned SEG_D = 3;
   localparam int unsigned SEG_E = 4;
   localparam int unsigned SEG_F = 5;
   localparam int unsigned SEG_G = 6;

endpackage

// File: rtl/bcd_to_7.sv
// Combinational hex nibble to 7-segment decoder, active-high segments.
module bcd_to_7
   import seg_scan_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg_c
);

   logic [6:0] pat;

   // Glyph table in {g,f,e,d,c,b,a} order, then placed on the segment bus
   always_comb begin
      pat = SEG_OFF;
      case (digit)
         4'h0: pat = 7'b0111111;
         4'h1: pat = 7'b0000110;
         4'h2: pat = 7'b1011011;
         4'h3: pat = 7'b1001111;
         4'h4: pat = 7'b1100110;
         4'h5: pat = 7'b1101101;
         4'h6: pat = 7'b1111101;
         4'h7: pat = 7'b0000111;
         4'h8: pat = 7'b1111111;
         4'h9: pat = 7'b1101111;
         4'ha: pat = 7'b1110111;
         4'hb: pat = 7'b1111100;
         4'hc: pat = 7'b0111001;
         4'hd: pat = 7'b1011110;
         4'he: pat = 7'b1111001;
         default: pat = 7'b1110001;
      endcase
      seg_c        = SEG_OFF;
      seg_c[SEG_A] = pat[0];
      seg_c[SEG_B] = pat[1];
      seg_c[SEG_C] = pat[2];
      seg_c[SEG_D] = pat[3];
      seg_c[SEG_E] = pat[4];
      seg_c[SEG_F] = pat[5];
      seg_c[SEG_G] = pat[6];
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed N-digit 7-segment scan controller with shadow-buffered value.
// Optional leading-zero blanking is enabled with `define SEG_SCAN_LZB_EN.
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int unsigned N_DIGITS     = 4,
   parameter int unsigned TICK_DIV     = 50000,
   parameter int unsigned BLANK_CYCLES = 2,
   localparam int unsigned IDX_W       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic [4*N_DIGITS-1:0] value_in,
   input  logic                  load,
   output logic [N_DIGITS-1:0]   an,
   output logic [6:0]            seg,
   output logic [IDX_W-1:0]      digit_idx,
   output logic                  frame_done
);

   localparam int unsigned VW    = 4 * N_DIGITS;
   localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] LAST_BLANK = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_DIGITS - 1);
   localparam state_t           SLOT_START = (BLANK_CYCLES == 0) ? SHOW : BLANK;

   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [IDX_W-1:0]  idx_n;
   logic [VW-1:0]     active_reg, active_n;
   logic [VW-1:0]     pending_reg, pending_n;
   logic              pending_valid, pvalid_n;
   logic              boundary;
   logic [3:0]        nibble;
   logic [6:0]        dec_seg;
   logic              lzb_blank;
   logic [N_DIGITS-1:0] an_n;
   logic [6:0]        seg_n;
   logic              frame_done_n;

   assign nibble = active_n[{idx_n, 2'b00} +: 4];

   bcd_to_7 u_dec (
      .digit (nibble),
      .seg_c (dec_seg)
   );

`ifdef SEG_SCAN_LZB_EN
   logic [VW-1:0] upper;

   // Blank a digit when it and every more-significant nibble are zero
   always_comb begin
      upper     = active_n >> {idx_n, 2'b00};
      lzb_blank = (idx_n != '0) && (upper == '0);
   end
`else
   assign lzb_blank = 1'b0;
`endif

   // Next-state, slot counter and digit index
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      idx_n    = digit_idx;
      boundary = (state == SHOW) && (digit_idx == LAST_IDX) && (cnt == LAST_CNT);
      if (!en) begin
         state_n = IDLE;
         cnt_n   = '0;
         idx_n   = '0;
      end else begin
         case (state)
            IDLE: begin
               state_n = SLOT_START;
               cnt_n   = '0;
               idx_n   = '0;
            end
            BLANK: begin
               cnt_n = cnt + CNT_W'(1);
               if (cnt == LAST_BLANK) state_n = SHOW;
            end
            SHOW: begin
               if (cnt == LAST_CNT) begin
                  state_n = SLOT_START;
                  cnt_n   = '0;
                  idx_n   = (digit_idx == LAST_IDX) ? '0 : digit_idx + IDX_W'(1);
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // Value buffering: active_reg only moves in IDLE or at the frame boundary
   always_comb begin
      active_n  = active_reg;
      pending_n = pending_reg;
      pvalid_n  = pending_valid;
      if (state == IDLE) begin
         if (load) begin
            active_n = value_in;
            pvalid_n = 1'b0;
         end else if (pending_valid) begin
            active_n = pending_reg;
            pvalid_n = 1'b0;
         end
      end else if (boundary) begin
         if (load)               active_n = value_in;
         else if (pending_valid) active_n = pending_reg;
         pvalid_n = 1'b0;
      end else if (load) begin
         pending_n = value_in;
         pvalid_n  = 1'b1;
      end
   end

   // Outputs derived from the state being entered so they align with digit_idx
   always_comb begin
      an_n         = '0;
      seg_n        = SEG_OFF;
      frame_done_n = (state_n == SHOW) && (idx_n == LAST_IDX) && (cnt_n == LAST_CNT);
      if (state_n == SHOW) begin
         an_n  = N_DIGITS'(1) << idx_n;
         seg_n = lzb_blank ? SEG_OFF : dec_seg;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         digit_idx     <= '0;
         an            <= '0;
         seg           <= SEG_OFF;
         frame_done    <= 1'b0;
         active_reg    <= '0;
         pending_reg   <= '0;
         pending_valid <= 1'b0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         digit_idx     <= idx_n;
         an            <= an_n;
         seg           <= seg_n;
         frame_done    <= frame_done_n;
         active_reg    <= active_n;
         pending_reg   <= pending_n;
         pending_valid <= pvalid_n;
      end
   end

endmodule
